fifo_drain_demux: RTL and testbench

//  Downstream stage of the 10-bit FIFO. Pops words while the FIFO is non-empty
//  and neither destination is paused, then routes each word to one of two

---
 rtl/fifo_drain_demux.sv | 91 +++++++++
 tb/tb_fifo_drain_demux.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_demux.sv
// Drain stage for an upstream FIFO. It pops words while data is available and
// no sink is paused, then steers each word to channel 0 or 1 using bit SEL_BIT.
module fifo_drain_demux #(
    parameter int TAMANO_DATOS     = 10,
    parameter int TAMANO_DIRECCION = 8,
    parameter int SEL_BIT          = 9,
    parameter int CNT_W            = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fifo_empty,
    input  logic [TAMANO_DATOS-1:0] fifo_data,
    input  logic                    pause0,
    input  logic                    pause1,
    output logic                    read_enable,
    output logic [TAMANO_DATOS-1:0] data_out0,
    output logic                    valid_out0,
    output logic [TAMANO_DATOS-1:0] data_out1,
    output logic                    valid_out1,
    output logic [CNT_W-1:0]        word_count,
    output logic [1:0]              state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t state_q;
    logic   rd_pending;
    logic   pause_any;

    // The upstream depth is informational only; nothing here is sized by it.
    logic unused_depth;
    assign unused_depth = (TAMANO_DIRECCION > 0);

    assign pause_any   = pause0 | pause1;
    assign read_enable = reset & (state_q == READ) & ~fifo_empty & ~pause_any;
    assign state       = state_q;

    // NOTE: every register here uses <= so all of them see pre-edge values of
    // each other; a blocking assignment would let rd_pending leak into the
    // capture logic in the same edge and shorten the pipeline by a cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rd_pending <= 1'b0;
            valid_out0 <= 1'b0;
            valid_out1 <= 1'b0;
            data_out0  <= '0;
            data_out1  <= '0;
            word_count <= '0;
        end else begin
            // Pause is checked first in every state so it wins over empty.
            case (state_q)
                IDLE: begin
                    if (pause_any)        state_q <= PAUSE;
                    else if (!fifo_empty) state_q <= READ;
                end
                READ: begin
                    if (pause_any)        state_q <= PAUSE;
                    else if (fifo_empty)  state_q <= IDLE;
                end
                PAUSE: begin
                    if (!pause_any)       state_q <= fifo_empty ? IDLE : READ;
                end
                // NOTE: the unused 2'b11 encoding is unreachable in normal
                // operation, but an explicit default recovers it to IDLE.
                default:                  state_q <= IDLE;
            endcase

            rd_pending <= read_enable;
            valid_out0 <= 1'b0;
            valid_out1 <= 1'b0;

            // fifo_data is valid the cycle after the pop, which rd_pending tracks.
            if (rd_pending) begin
                if (fifo_data[SEL_BIT]) begin
                    data_out1  <= fifo_data;
                    valid_out1 <= 1'b1;
                end else begin
                    data_out0  <= fifo_data;
                    valid_out0 <= 1'b1;
                end
                word_count <= word_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_demux.sv
// Bench for fifo_drain_demux: behavioural upstream FIFO, a scoreboard of popped
// words checked against delivered strobes, and one task per scenario.
module tb_fifo_drain_demux;

    localparam int DW    = 10;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             fifo_empty;
    logic [DW-1:0]    fifo_data;
    logic             pause0;
    logic             pause1;
    logic             read_enable;
    logic [DW-1:0]    data_out0;
    logic             valid_out0;
    logic [DW-1:0]    data_out1;
    logic             valid_out1;
    logic [CNT_W-1:0] word_count;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int valids = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sb_q[$];

    fifo_drain_demux #(
        .TAMANO_DATOS(DW),
        .TAMANO_DIRECCION(8),
        .SEL_BIT(9),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .pause0(pause0),
        .pause1(pause1),
        .read_enable(read_enable),
        .data_out0(data_out0),
        .valid_out0(valid_out0),
        .data_out1(data_out1),
        .valid_out1(valid_out1),
        .word_count(word_count),
        .state(state)
    );

    always #5 clk = ~clk;

    // Upstream FIFO: samples read_enable at the edge, presents data just after it.
    initial begin
        logic take;
        forever begin
            @(posedge clk);
            take = read_enable;
            #1;
            if (!reset) begin
                fifo_q.delete();
                sb_q.delete();
                fifo_empty = 1'b1;
            end else begin
                if (take) begin
                    checks++;
                    if (fifo_q.size() == 0) begin
                        errors++;
                        $display("FAIL underflow: pop with fifo size %0d, required >0", fifo_q.size());
                    end else begin
                        fifo_data = fifo_q.pop_front();
                        sb_q.push_back(fifo_data);
                        pops++;
                    end
                end
                fifo_empty = (fifo_q.size() == 0);
            end
        end
    end

    // Output monitor: each strobe must match the oldest outstanding pop.
    initial begin
        logic [DW-1:0] exp_w;
        logic [DW-1:0] got_w;
        logic          got_ch;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (valid_out0 === 1'b1 && valid_out1 === 1'b1) begin
                    checks++;
                    errors++;
                    $display("FAIL both_valid: valid_out0=1 valid_out1=1, required at most one");
                end
                if (valid_out0 === 1'b1 || valid_out1 === 1'b1) begin
                    valids++;
                    checks++;
                    got_ch = valid_out1;
                    got_w  = got_ch ? data_out1 : data_out0;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL orphan_valid: word %h on ch%0d with no pop outstanding", got_w, got_ch);
                    end else begin
                        exp_w = sb_q.pop_front();
                        if (got_w !== exp_w || got_ch !== exp_w[9]) begin
                            errors++;
                            $display("FAIL route: got %h on ch%0d, required %h on ch%0d",
                                     got_w, got_ch, exp_w, exp_w[9]);
                        end
                    end
                end
                if (read_enable === 1'b1) begin
                    checks++;
                    if (fifo_empty !== 1'b0 || state !== 2'b01 || pause0 !== 1'b0 || pause1 !== 1'b0) begin
                        errors++;
                        $display("FAIL re_qual: read_enable=1 with empty=%b state=%b p0=%b p1=%b, required 0/01/0/0",
                                 fifo_empty, state, pause0, pause1);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        pause0     = 1'b0;
        pause1     = 1'b0;
        step(2);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (read_enable !== 1'b0 || state !== 2'b00 || valid_out0 !== 1'b0 || valid_out1 !== 1'b0 ||
                data_out0 !== '0 || data_out1 !== '0 || word_count !== '0) begin
                errors++;
                $display("FAIL reset_state[%0d]: re=%b st=%b v0=%b v1=%b d0=%h d1=%h cnt=%0d, required all 0",
                         k, read_enable, state, valid_out0, valid_out1, data_out0, data_out1, word_count);
            end
            reset = 1'b1;
            step(2);
        end
    endtask

    task automatic test_basic_route();
        logic [DW-1:0] exp_d[3];
        logic          exp_c[3];
        int            vcyc[$];
        logic [DW-1:0] vdat[$];
        logic          vch[$];
        int            re_n = 0;
        exp_d[0] = 10'h005; exp_c[0] = 1'b0;
        exp_d[1] = 10'h205; exp_c[1] = 1'b1;
        exp_d[2] = 10'h1FF; exp_c[2] = 1'b0;
        for (int k = 0; k < 3; k++) push(exp_d[k]);
        for (int i = 0; i < 15; i++) begin
            step();
            if (read_enable === 1'b1) re_n++;
            if (valid_out0 === 1'b1 || valid_out1 === 1'b1) begin
                vcyc.push_back(i);
                vch.push_back(valid_out1);
                vdat.push_back(valid_out1 ? data_out1 : data_out0);
            end
        end
        checks++;
        if (re_n != 3) begin
            errors++;
            $display("FAIL basic_re_cycles: got %0d, required 3", re_n);
        end
        checks++;
        if (vcyc.size() != 3) begin
            errors++;
            $display("FAIL basic_valid_count: got %0d, required 3", vcyc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (vdat[k] !== exp_d[k] || vch[k] !== exp_c[k] || vcyc[k] != vcyc[0] + k) begin
                    errors++;
                    $display("FAIL basic_word[%0d]: got %h ch%0d cyc %0d, required %h ch%0d cyc %0d",
                             k, vdat[k], vch[k], vcyc[k], exp_d[k], exp_c[k], vcyc[0] + k);
                end
            end
        end
        checks++;
        if (word_count !== 8'd3 || state !== 2'b00) begin
            errors++;
            $display("FAIL basic_end: cnt=%0d state=%b, required 3/00", word_count, state);
        end
    endtask

    task automatic test_pause();
        int p0 = pops;
        int v0 = valids;
        int n  = 0;
        for (int k = 0; k < 8; k++) push(DW'($urandom_range(0, 1023)));
        while (pops - p0 < 3 && n < 30) begin
            step();
            n++;
        end
        pause1 = 1'b1;
        #1;
        checks++;
        if (read_enable !== 1'b0 || pops - p0 != 3) begin
            errors++;
            $display("FAIL pause_drop: re=%b pops=%0d, required 0/3", read_enable, pops - p0);
        end
        step(5);
        checks++;
        if (pops - p0 != 3 || valids - v0 != 3 || state !== 2'b10 || read_enable !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold: pops=%0d valids=%0d state=%b re=%b, required 3/3/10/0",
                     pops - p0, valids - v0, state, read_enable);
        end
        pause1 = 1'b0;
        n = 0;
        while ((pops - p0 < 8 || sb_q.size() != 0) && n < 40) begin
            step();
            n++;
        end
        step(3);
        checks++;
        if (pops - p0 != 8 || valids - v0 != 8 || state !== 2'b00) begin
            errors++;
            $display("FAIL pause_resume: pops=%0d valids=%0d state=%b, required 8/8/00",
                     pops - p0, valids - v0, state);
        end
    endtask

    task automatic test_empty_mid_burst();
        int v0       = valids;
        int re_n     = 0;
        int bad      = 0;
        int refill_i = -1;
        for (int k = 0; k < 3; k++) push(DW'($urandom_range(0, 1023)));
        for (int i = 0; i < 25; i++) begin
            step();
            if (read_enable === 1'b1) re_n++;
            if (read_enable === 1'b1 && fifo_empty === 1'b1) bad++;
            if (refill_i < 0 && i > 0 && fifo_empty === 1'b1) refill_i = i + 1;
            if (i == refill_i) for (int k = 0; k < 3; k++) push(DW'($urandom_range(0, 1023)));
        end
        checks++;
        if (re_n != 6 || bad != 0) begin
            errors++;
            $display("FAIL empty_re: re_cycles=%0d re_while_empty=%0d, required 6/0", re_n, bad);
        end
        checks++;
        if (valids - v0 != 6 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL empty_delivery: valids=%0d outstanding=%0d, required 6/0", valids - v0, sb_q.size());
        end
    endtask

    task automatic test_reset_in_flight();
        int p0 = pops;
        int v0 = valids;
        int n  = 0;
        push(10'h0AA);
        push(10'h2BB);
        while (pops == p0 && n < 20) begin
            step();
            n++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (valid_out0 !== 1'b0 || valid_out1 !== 1'b0 || word_count !== '0 ||
            state !== 2'b00 || read_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: v0=%b v1=%b cnt=%0d state=%b re=%b, required 0/0/0/00/0",
                     valid_out0, valid_out1, word_count, state, read_enable);
        end
        step(2);
        checks++;
        if (valids != v0 || valid_out0 !== 1'b0 || valid_out1 !== 1'b0 || pops - p0 != 1) begin
            errors++;
            $display("FAIL reset_discard: new valids=%0d pops=%0d, required 0/1", valids - v0, pops - p0);
        end
        reset = 1'b1;
        step(2);
    endtask

    task automatic test_wrap_random_pause();
        int p0 = pops;
        int v0 = valids;
        int n  = 0;
        for (int k = 0; k < 257; k++) push(DW'($urandom_range(0, 1023)));
        while ((pops - p0 < 257 || sb_q.size() != 0) && n < 3000) begin
            pause0 = ($urandom_range(0, 7) == 0);
            pause1 = ($urandom_range(0, 7) == 0);
            step();
            n++;
        end
        pause0 = 1'b0;
        pause1 = 1'b0;
        step(4);
        checks++;
        if (word_count !== 8'd1) begin
            errors++;
            $display("FAIL wrap_count: got %0d, required 1", word_count);
        end
        checks++;
        if (pops - p0 != 257 || valids - v0 != 257) begin
            errors++;
            $display("FAIL wrap_balance: pops=%0d valids=%0d, required 257/257", pops - p0, valids - v0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_route();
        test_pause();
        test_empty_mid_burst();
        test_reset_in_flight();
        test_wrap_random_pause();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
